// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS core pipeline: decode-to-execute stage state
// encoding and the default layout of one D2E entry.
package mips_core_pkg;

    localparam int INSTRUCTION_ID_W = 20;
    localparam int D2E_DATA_W       = 32;
    localparam int D2E_CTL_W        = 24;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } D2eState;

    // Default-width entry; the stage builds its own entry type from its
    // parameters with the same field order.
    typedef struct packed {
        logic [INSTRUCTION_ID_W-1:0] id;
        logic [D2E_DATA_W-1:0]       rs_data;
        logic [D2E_DATA_W-1:0]       rt_data;
        logic [D2E_CTL_W-1:0]        ctl;
    } D2eEntry;

endpackage

// File: rtl/d2e_entry.sv
// One D2E entry register: load-enable, asynchronous reset to zero.
module d2e_entry
    import mips_core_pkg::*;
#(
    parameter type entry_t = D2eEntry
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_ld,
    input  entry_t i_d,
    output entry_t o_q
);

    entry_t entry_d;
    entry_t entry_q;

    // Take new contents only when loaded, otherwise hold.
    always_comb begin
        entry_d = entry_q;
        if (i_ld) entry_d = i_d;
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry_d;
    end

    assign o_q = entry_q;

endmodule

// File: rtl/d2e_stage.sv
// Decode-to-execute pipeline stage with a one-entry skid register so that
// o_ready comes straight from the state flop. Handles load-use bubbles,
// misprediction flush and EX backpressure.
// Optional: define D2E_PERF_COUNTERS_EN to add bubble/stall counters.
module d2e_stage
    import mips_core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ID_W   = INSTRUCTION_ID_W,
    parameter int CTL_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ID_W-1:0]   i_instruction_id,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [CTL_W-1:0]  i_ctl,
    input  logic              i_lw_hazard,
    input  logic              i_flush,
    input  logic              i_ex_ready,
`ifdef D2E_PERF_COUNTERS_EN
    output logic [31:0]       o_bubble_cnt,
    output logic [31:0]       o_stall_cnt,
`endif
    output logic              o_valid,
    output logic [ID_W-1:0]   o_instruction_id,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    output logic [CTL_W-1:0]  o_ctl
);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [CTL_W-1:0]  ctl;
    } entry_t;

    D2eState state_d, state_q;
    logic    accept, xfer;
    logic    main_ld, skid_ld, main_from_skid;
    entry_t  in_entry, main_din, main_q, skid_q;

    assign o_ready = (state_q != SKID);
    assign o_valid = (state_q != EMPTY);
    assign accept  = i_valid & o_ready & ~i_lw_hazard & ~i_flush;
    assign xfer    = o_valid & i_ex_ready;

    assign in_entry = '{id: i_instruction_id, rs_data: i_rs_data,
                        rt_data: i_rt_data, ctl: i_ctl};
    assign main_din = main_from_skid ? skid_q : in_entry;

    // Next state and register load enables; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                    main_ld = 1'b1;
                end
            end
            FULL: begin
                if (accept && xfer) begin
                    main_ld = 1'b1;
                end else if (accept) begin
                    state_d = SKID;
                    skid_ld = 1'b1;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                // o_ready is low here, so only the skid entry can move up.
                if (xfer) begin
                    state_d        = FULL;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Data may be left stale on flush; only the state matters.
        if (i_flush) state_d = EMPTY;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    d2e_entry #(.entry_t(entry_t)) u_main (
        .clk  (clk),
        .rst  (rst),
        .i_ld (main_ld),
        .i_d  (main_din),
        .o_q  (main_q)
    );

    d2e_entry #(.entry_t(entry_t)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .i_ld (skid_ld),
        .i_d  (in_entry),
        .o_q  (skid_q)
    );

    assign o_instruction_id = main_q.id;
    assign o_rs_data        = main_q.rs_data;
    assign o_rt_data        = main_q.rt_data;
    assign o_ctl            = main_q.ctl;

`ifdef D2E_PERF_COUNTERS_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;

    // Saturating event counters for hazard bubbles and EX stalls.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (i_valid && i_lw_hazard && !i_flush && bubble_cnt_q != '1)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        if (o_valid && !i_ex_ready && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign o_bubble_cnt = bubble_cnt_q;
    assign o_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: doc/d2e_stage.md
Name: d2e_stage

Overview:
- Decode-to-execute pipeline stage, directly downstream of the decode-stage forwarding logic.
- Registers the forwarded operands, packed decoder control and the 20-bit instruction ID, and presents them to EX.
- Handles load-use bubbles, branch-misprediction flush and EX backpressure.
- Holds up to two entries (main register plus a one-entry skid register) so that `o_ready` is a registered signal.

Parameters:
- DATA_W, 32, operand width.
- ID_W, 20, instruction ID width.
- CTL_W, 24, width of the packed decoder control bundle (alu_ctl, rw_addr, uses_rw, is_mem_access, …).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  decode presents an instruction.
- o_ready  out  1  stage can accept an instruction this cycle.
- i_instruction_id  in  ID_W  ID of the incoming instruction.
- i_rs_data  in  DATA_W  forwarded rs operand.
- i_rt_data  in  DATA_W  forwarded rt operand.
- i_ctl  in  CTL_W  decoder control bundle.
- i_lw_hazard  in  1  load-use hazard from the forwarding logic.
- i_flush  in  1  branch misprediction; kill all held and incoming instructions.
- i_ex_ready  in  1  EX accepts the presented entry.
- o_valid  out  1  output entry is valid.
- o_instruction_id  out  ID_W  ID of the output entry.
- o_rs_data  out  DATA_W  rs operand of the output entry.
- o_rt_data  out  DATA_W  rt operand of the output entry.
- o_ctl  out  CTL_W  control bundle of the output entry.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high.
- Reset values:
  - state = EMPTY; `o_valid` = 0; `o_ready` = 1.
  - `o_instruction_id`, `o_rs_data`, `o_rt_data`, `o_ctl` all 0; skid register contents 0.
- Output and ready sourcing:
  - `o_ready` = (state != SKID); depends on the state register only.
  - `o_*` outputs are driven directly from the main register.
- Handshake definitions:
  - accept = i_valid & o_ready & ~i_lw_hazard & ~i_flush.
  - xfer = o_valid & i_ex_ready.
- States:
  - EMPTY: nothing held.
  - FULL: main register valid.
  - SKID: main and skid registers both valid.
- Transitions (i_flush = 0):
  - EMPTY: accept → FULL, main ← input.
  - FULL: accept & xfer → FULL, main ← input.
  - FULL: accept & ~xfer → SKID, skid ← input.
  - FULL: ~accept & xfer → EMPTY.
  - FULL: neither → stay FULL.
  - SKID: xfer → FULL, main ← skid; the input is not accepted because o_ready = 0.
  - SKID: otherwise → stay SKID.
- Latency:
  - Accepted in cycle N → visible on `o_*` in cycle N+1 when the stage was EMPTY, or FULL with xfer.
  - Sustained throughput is 1 per cycle.
- Ordering: entries leave strictly in acceptance order; no instruction is duplicated or dropped except by flush.
- Load-use hazard:
  - `i_lw_hazard` = 1 blocks accept; upstream holds its instruction.
  - If main drains that cycle, `o_valid` = 0 next cycle (bubble).
  - A hazard with no valid input has no effect.
- Flush:
  - `i_flush` has the highest priority.
  - Next state = EMPTY and both valids clear; data registers may hold stale values.
  - An instruction presented in the same cycle is dropped.
  - An xfer in the flush cycle still completes (EX has already sampled it).
- Reset mid-operation: asynchronous return to the reset values regardless of state.
- Stall with `i_ex_ready` = 0 in FULL/SKID: `o_*` hold stable.

Optional Feature:
- Macro: D2E_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs o_bubble_cnt (32) and o_stall_cnt (32), both reset to 0, saturating at 0xFFFF_FFFF.
  - bubble_cnt increments each cycle with i_valid & i_lw_hazard & ~i_flush.
  - stall_cnt increments each cycle with o_valid & ~i_ex_ready.
- Undefined: the ports and logic do not exist; behaviour is otherwise identical.

Decomposition:
- mips_core_pkg gets:
  - enum D2eState {EMPTY, FULL, SKID};
  - packed struct D2eEntry {id, rs_data, rt_data, ctl};
  - constant INSTRUCTION_ID_W = 20.
- One sub-module, d2e_entry:
  - a single D2eEntry register with load-enable and asynchronous reset to 0;
  - instantiated twice (main, skid).

Test Plan:
- Reset mid-operation: assert rst while in SKID (IDs 0x00005/0x00006 held) → same cycle o_valid = 0, o_ready = 1, o_instruction_id = 0.
- Streaming: IDs 1, 2, 3 on consecutive cycles, i_ex_ready = 1 → out in cycles +1, +2, +3 with rs_data / rt_data matching; o_ready stays 1.
- Backpressure: ID 5 in main, i_ex_ready = 0, ID 6 accepted → SKID, o_ready = 0 next cycle; release i_ex_ready → output 5, then 6, then o_valid = 0.
- Load-use hazard: ID 7 valid with i_lw_hazard = 1 for one cycle → not accepted, bubble (o_valid = 0); next cycle ID 7 accepted and appears one cycle later.
- Flush: in SKID, pulse i_flush with ID 9 at input → next cycle EMPTY, o_valid = 0, ID 9 never appears; a subsequent ID 10 passes normally.
- With D2E_PERF_COUNTERS_EN: 3 hazard cycles plus 4 EX-stall cycles → o_bubble_cnt = 3, o_stall_cnt = 4.
